// File: rtl/ls_mem_access.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ls_mem_access                                                |
// | Description : Load/store execute stage. It runs one outstanding data-bus   |
// |               request/ack transaction and formats big-endian load data.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ls_mem_access #(
    parameter int WAIT_LIMIT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_dec,
    input  logic        we,
    input  logic [1:0]  mode,
    input  logic        exts,
    input  logic        return_dout,
    input  logic        do_request,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [29:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        misaligned,
    output logic        bus_error
);

    localparam logic [0:0]            c_IDLE  = 1'b0;
    localparam logic [0:0]            c_REQ   = 1'b1;
    localparam int                    c_CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [c_CNT_W-1:0]    c_LAST  = c_CNT_W'(WAIT_LIMIT - 1);

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_addr;
    logic               r_we;
    logic [1:0]         r_mode;
    logic               r_exts;
    logic               r_ret;
    logic [3:0]         r_be;
    logic [31:0]        r_wdata;
    logic [31:0]        r_result;
    logic               r_rv;
    logic               r_mis;
    logic               r_berr;

    logic [0:0]  w_state_nxt;
    logic        w_accept;
    logic        w_aligned;
    logic        w_issue;
    logic        w_misal;
    logic        w_addr_ret;
    logic        w_ack;
    logic        w_timeout;
    logic [3:0]  w_be_nxt;
    logic [31:0] w_wdata_nxt;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic        w_rv_nxt;
    logic [31:0] w_result_nxt;

    // Only IDLE accepts ops; en_dec during a stall is dropped (and flagged below).
    assign w_accept   = (r_state == c_IDLE) && en_dec && (mode != 2'd0);
    assign w_issue    = w_accept && do_request && w_aligned;
    assign w_misal    = w_accept && do_request && !w_aligned;
    assign w_addr_ret = w_accept && !do_request && !return_dout;
    assign w_ack      = (r_state == c_REQ) && dbus_ack;
    assign w_timeout  = (r_state == c_REQ) && !dbus_ack && (r_cnt == c_LAST);

    always_comb begin
        w_aligned = 1'b1;
        case (mode)
            2'd2:    w_aligned = !addr[0];
            2'd3:    w_aligned = (addr[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_mode   <= 2'd0;
            r_exts   <= 1'b0;
            r_ret    <= 1'b0;
            r_be     <= 4'd0;
            r_wdata  <= '0;
            r_result <= '0;
            r_rv     <= 1'b0;
            r_mis    <= 1'b0;
            r_berr   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_result <= w_result_nxt;
            r_rv     <= w_rv_nxt;
            r_mis    <= w_misal;
            r_berr   <= w_timeout;
            if (w_issue) begin
                r_addr  <= addr;
                r_we    <= we;
                r_mode  <= mode;
                r_exts  <= exts;
                r_ret   <= return_dout;
                r_be    <= w_be_nxt;
                r_wdata <= w_wdata_nxt;
                r_cnt   <= '0;
            end else if (r_state == c_REQ) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_issue) w_state_nxt = c_REQ;
            c_REQ:   if (w_ack || w_timeout) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_be_nxt    = 4'b0000;
        w_wdata_nxt = wdata;
        case (mode)
            2'd1: begin
                w_be_nxt    = 4'b1000 >> addr[1:0];
                w_wdata_nxt = {4{wdata[7:0]}};
            end
            2'd2: begin
                w_be_nxt    = addr[1] ? 4'b0011 : 4'b1100;
                w_wdata_nxt = {2{wdata[15:0]}};
            end
            2'd3:    w_be_nxt = 4'b1111;
            default: w_be_nxt = 4'b0000;
        endcase

        // Byte offset 0 lives in the most significant lane (big-endian).
        w_byte = dbus_rdata[31:24];
        case (r_addr[1:0])
            2'd0:    w_byte = dbus_rdata[31:24];
            2'd1:    w_byte = dbus_rdata[23:16];
            2'd2:    w_byte = dbus_rdata[15:8];
            default: w_byte = dbus_rdata[7:0];
        endcase
        w_half = r_addr[1] ? dbus_rdata[15:0] : dbus_rdata[31:16];

        case (r_mode)
            2'd1:    w_load = {{24{r_exts & w_byte[7]}}, w_byte};
            2'd2:    w_load = {{16{r_exts & w_half[15]}}, w_half};
            default: w_load = dbus_rdata;
        endcase

        w_rv_nxt     = 1'b0;
        w_result_nxt = r_result;
        if (w_ack) begin
            if (!r_we) begin
                w_rv_nxt     = 1'b1;
                w_result_nxt = w_load;
            end else if (!r_ret) begin
                w_rv_nxt     = 1'b1;
                w_result_nxt = r_addr;
            end
        end else if (w_addr_ret) begin
            w_rv_nxt     = 1'b1;
            w_result_nxt = addr;
        end
    end

    assign stall        = (r_state == c_REQ);
    assign dbus_req     = (r_state == c_REQ);
    assign dbus_we      = r_we;
    assign dbus_addr    = r_addr[31:2];
    assign dbus_be      = r_be;
    assign dbus_wdata   = r_wdata;
    assign result       = r_result;
    assign result_valid = r_rv;
    assign misaligned   = r_mis;
    assign bus_error    = r_berr;

    a_no_op_while_stall: assert property (@(posedge clk) disable iff (reset) !(en_dec && stall));

endmodule
`default_nettype wire

// File: tb/tb_ls_mem_access.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ls_mem_access                                             |
// | Description : Randomised bench for ls_mem_access with a per-cycle model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ls_mem_access;
    localparam int WL   = 4;
    localparam int MAXC = 8192;

    logic        clk = 1'b0, reset = 1'b1;
    logic        en_dec = 1'b0, we = 1'b0, exts = 1'b0, return_dout = 1'b0, do_request = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] addr = '0, wdata = '0, dbus_rdata = '0;
    logic        dbus_ack = 1'b0;
    logic        stall, dbus_req, dbus_we, result_valid, misaligned, bus_error;
    logic [29:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata, result;

    ls_mem_access #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .reset(reset), .en_dec(en_dec), .we(we), .mode(mode), .exts(exts),
        .return_dout(return_dout), .do_request(do_request), .addr(addr), .wdata(wdata),
        .stall(stall), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .result(result), .result_valid(result_valid), .misaligned(misaligned), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    // Expected outputs, indexed by cycle number; untouched entries mean "idle".
    typedef struct packed {
        bit        req;
        bit        rv;
        bit        mis;
        bit        berr;
        bit        we;
        bit [3:0]  be;
        bit [29:0] addr;
        bit [31:0] wdata;
        bit [31:0] result;
    } exp_t;

    exp_t        exp_q [MAXC];
    exp_t        e_cur;
    int          cyc = 0;
    bit          chk_en = 1'b0;
    int          n_cmp = 0, n_bad = 0;
    int          rv_cnt = 0, mis_cnt = 0, berr_cnt = 0, stall_cnt = 0;
    logic [31:0] last_result = '0, last_wdata = '0;
    logic [3:0]  last_be = '0;
    logic [29:0] last_addr = '0;
    logic        last_we = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: actual=%h required=%h", name, cyc, act, exp_v);
        end
    endtask

    function automatic logic [3:0] m_be(input logic [1:0] m, input logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        case (m)
            2'd1:    return 4'(1 << (3 - off));
            2'd2:    return 4'(3 << (2 * (1 - int'(a[1]))));
            2'd3:    return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] m, input logic [31:0] wd);
        case (m)
            2'd1:    return {24'd0, wd[7:0]} * 32'h0101_0101;
            2'd2:    return {16'd0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] m, input logic [31:0] a,
                                           input bit ex, input logic [31:0] rd);
        logic [31:0] v;
        v = rd;
        if (m == 2'd1) begin
            v = (rd >> (8 * (3 - int'(a[1:0])))) & 32'hFF;
            if (ex && v[7]) v = v | 32'hFFFF_FF00;
        end else if (m == 2'd2) begin
            v = (rd >> (a[1] ? 0 : 16)) & 32'hFFFF;
            if (ex && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Drives one op in the current cycle and records what each following cycle must show.
    // ack_d = 0 means no ack (timeout); rst_at > 0 asserts reset in that REQ cycle.
    task automatic do_op(input bit en, input bit w, input logic [1:0] m, input bit ex,
                         input bit ret, input bit dr, input logic [31:0] a, input logic [31:0] wd,
                         input int ack_d, input logic [31:0] rd, input int rst_at);
        int c, n;
        bit ok;
        c = cyc;
        en_dec = en; we = w; mode = m; exts = ex; return_dout = ret; do_request = dr;
        addr = a; wdata = wd;
        dbus_ack   = ($urandom_range(0, 3) == 0);
        dbus_rdata = $urandom;
        if (!en || m == 2'd0) begin
            step(); en_dec = 1'b0; dbus_ack = 1'b0; return;
        end
        if (!dr) begin
            if (!ret) begin
                exp_q[c+1].rv     = 1'b1;
                exp_q[c+1].result = a;
            end
            step(); en_dec = 1'b0; dbus_ack = 1'b0; return;
        end
        ok = (m == 2'd1) || (m == 2'd2 && !a[0]) || (m == 2'd3 && a[1:0] == 2'b00);
        if (!ok) begin
            exp_q[c+1].mis = 1'b1;
            step(); en_dec = 1'b0; dbus_ack = 1'b0; return;
        end
        n = (ack_d == 0) ? WL : ack_d;
        for (int i = 1; i <= n; i++) begin
            if (rst_at > 0 && i > rst_at) break;
            exp_q[c+i].req   = 1'b1;
            exp_q[c+i].we    = w;
            exp_q[c+i].addr  = a[31:2];
            exp_q[c+i].be    = m_be(m, a);
            exp_q[c+i].wdata = m_wdata(m, wd);
        end
        if (rst_at == 0) begin
            if (ack_d == 0) begin
                exp_q[c+n+1].berr = 1'b1;
            end else if (!w) begin
                exp_q[c+n+1].rv     = 1'b1;
                exp_q[c+n+1].result = m_load(m, a, ex, rd);
            end else if (!ret) begin
                exp_q[c+n+1].rv     = 1'b1;
                exp_q[c+n+1].result = a;
            end
        end
        step();
        for (int i = 1; i <= n; i++) begin
            en_dec = 1'b0; we = 1'($urandom); mode = 2'($urandom); exts = 1'($urandom);
            return_dout = 1'($urandom); do_request = 1'($urandom); addr = $urandom; wdata = $urandom;
            dbus_ack = 1'b0; dbus_rdata = $urandom;
            if (rst_at == i) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                return;
            end
            if (ack_d != 0 && i == n) begin
                dbus_ack   = 1'b1;
                dbus_rdata = rd;
            end
            step();
        end
        dbus_ack = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            e_cur = exp_q[cyc];
            chk("dbus_req", 32'(dbus_req), 32'(e_cur.req));
            chk("stall", 32'(stall), 32'(e_cur.req));
            chk("result_valid", 32'(result_valid), 32'(e_cur.rv));
            chk("misaligned", 32'(misaligned), 32'(e_cur.mis));
            chk("bus_error", 32'(bus_error), 32'(e_cur.berr));
            if (e_cur.req) begin
                chk("dbus_we", 32'(dbus_we), 32'(e_cur.we));
                chk("dbus_addr", 32'(dbus_addr), 32'(e_cur.addr));
                chk("dbus_be", 32'(dbus_be), 32'(e_cur.be));
                chk("dbus_wdata", dbus_wdata, e_cur.wdata);
            end
            if (e_cur.rv) chk("result", result, e_cur.result);
            if (stall) begin
                stall_cnt++;
                last_be    = dbus_be;
                last_wdata = dbus_wdata;
                last_addr  = dbus_addr;
                last_we    = dbus_we;
            end
            if (result_valid) begin
                rv_cnt++;
                last_result = result;
            end
            if (misaligned) mis_cnt++;
            if (bus_error) berr_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, r0, m0, b0;
        for (int i = 0; i < MAXC; i++) exp_q[i] = '0;
        reset = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        chk("reset_result", result, 32'h0);
        reset = 1'b0;
        step();

        // Load word, ack after 3 REQ cycles.
        s0 = stall_cnt; r0 = rv_cnt;
        do_op(1, 0, 2'd3, 0, 1, 1, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, 0);
        step();
        chk("lw_result", last_result, 32'hDEAD_BEEF);
        chk("lw_stall_cycles", 32'(stall_cnt - s0), 32'd3);
        chk("lw_rv_pulses", 32'(rv_cnt - r0), 32'd1);
        chk("lw_dbus_addr", 32'(last_addr), 32'h40);
        chk("lw_be", 32'(last_be), 32'hF);

        // Load byte at offset 3, same-cycle ack, signed then unsigned.
        do_op(1, 0, 2'd1, 1, 1, 1, 32'h103, 32'h0, 1, 32'h1122_33F0, 0);
        step();
        chk("lb_sext_result", last_result, 32'hFFFF_FFF0);
        chk("lb_be", 32'(last_be), 32'h1);
        do_op(1, 0, 2'd1, 0, 1, 1, 32'h103, 32'h0, 1, 32'h1122_33F0, 0);
        step();
        chk("lb_zext_result", last_result, 32'h0000_00F0);

        // Store halfword with update.
        do_op(1, 1, 2'd2, 0, 0, 1, 32'h22, 32'hABCD_1234, 2, 32'h0, 0);
        step();
        chk("sh_be", 32'(last_be), 32'h3);
        chk("sh_wdata", last_wdata, 32'h1234_1234);
        chk("sh_we", 32'(last_we), 32'h1);
        chk("sh_result", last_result, 32'h22);

        // Misaligned word then halfword.
        s0 = stall_cnt; m0 = mis_cnt;
        do_op(1, 0, 2'd3, 0, 1, 1, 32'h102, 32'h0, 1, 32'h0, 0);
        do_op(1, 0, 2'd2, 0, 1, 1, 32'h101, 32'h0, 1, 32'h0, 0);
        step();
        chk("misal_pulses", 32'(mis_cnt - m0), 32'd2);
        chk("misal_no_req", 32'(stall_cnt - s0), 32'd0);

        // Timeout, then a late ack that must be ignored.
        s0 = stall_cnt; r0 = rv_cnt; b0 = berr_cnt;
        do_op(1, 0, 2'd3, 0, 1, 1, 32'h200, 32'h0, 0, 32'h0, 0);
        dbus_ack = 1'b1;
        step();
        dbus_ack = 1'b0;
        step();
        chk("to_req_cycles", 32'(stall_cnt - s0), 32'(WL));
        chk("to_bus_error", 32'(berr_cnt - b0), 32'd1);
        chk("to_no_result", 32'(rv_cnt - r0), 32'd0);

        // Reset mid-REQ, then a normal op.
        r0 = rv_cnt;
        do_op(1, 0, 2'd3, 0, 1, 1, 32'h300, 32'h0, 3, 32'h5555_AAAA, 2);
        step();
        chk("rst_no_result", 32'(rv_cnt - r0), 32'd0);
        do_op(1, 0, 2'd2, 1, 1, 1, 32'h302, 32'h0, 2, 32'h1234_8001, 0);
        step();
        chk("after_rst_result", last_result, 32'hFFFF_8001);

        for (int k = 0; k < 300 && cyc < MAXC - 20; k++) begin
            bit          r_en, r_w, r_ex, r_ret, r_dr;
            logic [1:0]  r_m;
            logic [31:0] r_a;
            int          r_ad, r_ra;
            r_en  = ($urandom_range(0, 9) != 0);
            r_w   = 1'($urandom);
            r_ex  = 1'($urandom);
            r_ret = 1'($urandom);
            r_dr  = ($urandom_range(0, 4) != 0);
            r_m   = 2'($urandom);
            r_a   = $urandom;
            if ($urandom_range(0, 1) == 0) r_a[1:0] = 2'b00;
            r_ad  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, WL - 1));
            r_ra  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, (r_ad == 0) ? WL : r_ad)) : 0;
            do_op(r_en, r_w, r_m, r_ex, r_ret, r_dr, r_a, $urandom, r_ad, $urandom, r_ra);
        end

        en_dec = 1'b0;
        dbus_ack = 1'b0;
        step();
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
